// File: rtl/bch_peterson_solver.sv
// Peterson key-equation solver for BCH(15,5) t=3: odd syndromes in, error-locator sigma(x) out.
// Latency 11 cycles accept-to-out_valid; in_ready only in IDLE, result held until out_ready.
module bch_peterson_solver #(
    parameter int         M         = 4,
    parameter logic [M:0] PRIM_POLY = 5'b10011
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [M-1:0] s1,
    input  logic [M-1:0] s3,
    input  logic [M-1:0] s5,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [M-1:0] sigma1,
    output logic [M-1:0] sigma2,
    output logic [M-1:0] sigma3,
    output logic [1:0]   err_count,
    output logic         uncorrectable
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t       state_q, state_d;
    logic [3:0]   step_q, step_d;
    logic [M-1:0] s1_q, s3_q, s5_q, t2_q, t3_q, d_q, n_q, t5_q;
    logic [M-1:0] d2_q, d4_q, d8_q, p_q, inv_q, sig2_q;
    logic [M-1:0] sigma1_q, sigma2_q, sigma3_q;
    logic [1:0]   err_count_q;
    logic         unc_q;

    logic [M-1:0] mul_a, mul_b, prod;
    logic [M-1:0] res1, res2, res3;
    logic [1:0]   res_cnt;
    logic         res_unc;
    logic         accept, last_step;

    function automatic logic [M-1:0] gf_mul(input logic [M-1:0] a, input logic [M-1:0] b);
        logic [M-1:0] r;
        r = '0;
        for (int i = M - 1; i >= 0; i--) begin
            r = r[M-1] ? ({r[M-2:0], 1'b0} ^ PRIM_POLY[M-1:0]) : {r[M-2:0], 1'b0};
            if (b[i]) r = r ^ a;
        end
        return r;
    endfunction

    assign in_ready  = (state_q == IDLE);
    assign accept    = in_valid && in_ready;
    assign last_step = (state_q == CALC) && (step_q == 4'd10);

    // Operand schedule for the single shared multiplier.
    always_comb begin
        mul_a = s1_q;
        mul_b = s1_q;
        case (step_q)
            4'd0:    begin mul_a = s1_q;   mul_b = s1_q;  end
            4'd1:    begin mul_a = t2_q;   mul_b = s1_q;  end
            4'd2:    begin mul_a = t2_q;   mul_b = s3_q;  end
            4'd3:    begin mul_a = t3_q;   mul_b = t2_q;  end
            4'd4:    begin mul_a = d_q;    mul_b = d_q;   end
            4'd5:    begin mul_a = d2_q;   mul_b = d2_q;  end
            4'd6:    begin mul_a = d4_q;   mul_b = d4_q;  end
            4'd7:    begin mul_a = d2_q;   mul_b = d4_q;  end
            4'd8:    begin mul_a = p_q;    mul_b = d8_q;  end
            4'd9:    begin mul_a = n_q;    mul_b = inv_q; end
            4'd10:   begin mul_a = s1_q;   mul_b = sig2_q; end
            default: begin mul_a = s1_q;   mul_b = s1_q;  end
        endcase
        prod = gf_mul(mul_a, mul_b);
    end

    // Classify the syndromes; prod holds S1*sig2 during the final step.
    always_comb begin
        res1    = '0;
        res2    = '0;
        res3    = '0;
        res_cnt = 2'd0;
        res_unc = 1'b0;
        if (d_q != '0) begin
            res1    = s1_q;
            res2    = sig2_q;
            res3    = d_q ^ prod;
            res_cnt = ((d_q ^ prod) != '0) ? 2'd3 : 2'd2;
        end else if (s5_q == t5_q) begin
            res1    = s1_q;
            res_cnt = (s1_q != '0) ? 2'd1 : 2'd0;
        end else begin
            res_unc = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        case (state_q)
            IDLE: if (accept) begin
                state_d = CALC;
                step_d  = 4'd0;
            end
            CALC: if (last_step) begin
                state_d = DONE;
                step_d  = 4'd0;
            end else begin
                step_d = step_q + 4'd1;
            end
            DONE: if (out_ready) state_d = IDLE;
            default: begin
                state_d = IDLE;
                step_d  = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            step_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= '0; s3_q <= '0; s5_q <= '0; t2_q <= '0; t3_q <= '0;
            d_q  <= '0; n_q  <= '0; t5_q <= '0; d2_q <= '0; d4_q <= '0;
            d8_q <= '0; p_q  <= '0; inv_q <= '0; sig2_q <= '0;
            sigma1_q <= '0; sigma2_q <= '0; sigma3_q <= '0;
            err_count_q <= 2'd0; unc_q <= 1'b0;
        end else if (accept) begin
            s1_q <= s1;
            s3_q <= s3;
            s5_q <= s5;
        end else if (state_q == CALC) begin
            case (step_q)
                4'd0: t2_q <= prod;
                4'd1: begin t3_q <= prod; d_q <= prod ^ s3_q; end
                4'd2: n_q <= prod ^ s5_q;
                4'd3: t5_q <= prod;
                4'd4: d2_q <= prod;
                4'd5: d4_q <= prod;
                4'd6: d8_q <= prod;
                4'd7: p_q <= prod;
                4'd8: inv_q <= prod;
                4'd9: sig2_q <= prod;
                4'd10: begin
                    sigma1_q    <= res1;
                    sigma2_q    <= res2;
                    sigma3_q    <= res3;
                    err_count_q <= res_cnt;
                    unc_q       <= res_unc;
                end
                default: ;
            endcase
        end
    end

    assign out_valid     = (state_q == DONE);
    assign sigma1        = sigma1_q;
    assign sigma2        = sigma2_q;
    assign sigma3        = sigma3_q;
    assign err_count     = err_count_q;
    assign uncorrectable = unc_q;
endmodule

// File: tb/tb_bch_peterson_solver.sv
// Directed bench for bch_peterson_solver: hand-computed GF(16) vectors, latency and handshake checks.
module tb_bch_peterson_solver;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] s1 = '0, s3 = '0, s5 = '0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [3:0] sigma1, sigma2, sigma3;
    logic [1:0] err_count;
    logic       uncorrectable;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    bch_peterson_solver dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .s1(s1), .s3(s3), .s5(s5),
        .out_valid(out_valid), .out_ready(out_ready),
        .sigma1(sigma1), .sigma2(sigma2), .sigma3(sigma3),
        .err_count(err_count), .uncorrectable(uncorrectable)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_result(input string tag, input logic [3:0] e1, input logic [3:0] e2,
                              input logic [3:0] e3, input logic [1:0] ec, input logic eu);
        chk({tag, "_valid"}, {7'd0, out_valid}, 8'd1);
        chk({tag, "_sigma1"}, {4'd0, sigma1}, {4'd0, e1});
        chk({tag, "_sigma2"}, {4'd0, sigma2}, {4'd0, e2});
        chk({tag, "_sigma3"}, {4'd0, sigma3}, {4'd0, e3});
        chk({tag, "_errcnt"}, {6'd0, err_count}, {6'd0, ec});
        chk({tag, "_unc"}, {7'd0, uncorrectable}, {7'd0, eu});
    endtask

    // Present a triple, then scramble inputs right after the accepting edge.
    task automatic start(input string tag, input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
        @(negedge clk);
        in_valid = 1'b1; s1 = a; s3 = b; s5 = c;
        chk({tag, "_in_ready"}, {7'd0, in_ready}, 8'd1);
        @(posedge clk); #1;
        in_valid = 1'b0; s1 = ~a; s3 = ~b; s5 = ~c;
        chk({tag, "_busy"}, {7'd0, in_ready}, 8'd0);
    endtask

    task automatic run_vec(input string tag, input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                           input logic [3:0] e1, input logic [3:0] e2, input logic [3:0] e3,
                           input logic [1:0] ec, input logic eu);
        start(tag, a, b, c);
        repeat (10) @(posedge clk);
        #1 chk({tag, "_early"}, {7'd0, out_valid}, 8'd0);
        @(posedge clk);
        #1 chk_result(tag, e1, e2, e3, ec, eu);
    endtask

    task automatic release_out(input string tag);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, "_drop"}, {7'd0, out_valid}, 8'd0);
        chk({tag, "_idle"}, {7'd0, in_ready}, 8'd1);
    endtask

    initial begin
        #1;
        chk("rst_in_ready", {7'd0, in_ready}, 8'd1);
        chk("rst_out_valid", {7'd0, out_valid}, 8'd0);
        chk("rst_sigma", {sigma1, sigma2}, 8'h00);
        chk("rst_misc", {sigma3, 1'b0, uncorrectable, err_count}, 8'h00);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;

        run_vec("T1", 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 2'd0, 1'b0);
        release_out("T1");
        run_vec("T2", 4'h2, 4'h8, 4'h6, 4'h2, 4'h0, 4'h0, 2'd1, 1'b0);
        release_out("T2");
        run_vec("T3", 4'h3, 4'h9, 4'h7, 4'h3, 4'h2, 4'h0, 2'd2, 1'b0);
        release_out("T3");
        run_vec("T5", 4'h0, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0, 2'd0, 1'b1);
        release_out("T5");
        run_vec("T4", 4'h7, 4'h5, 4'h0, 4'h7, 4'hE, 4'h8, 2'd3, 1'b0);

        // Backpressure: result held, new input refused.
        @(negedge clk);
        in_valid = 1'b1; s1 = 4'h3; s3 = 4'h9; s5 = 4'h7;
        repeat (5) @(posedge clk);
        #1 chk_result("T6_hold", 4'h7, 4'hE, 4'h8, 2'd3, 1'b0);
        chk("T6_hold_rdy", {7'd0, in_ready}, 8'd0);
        @(negedge clk) in_valid = 1'b0;
        release_out("T6");

        // Abort a T3 run at step 4 with reset.
        start("T6_abort", 4'h3, 4'h9, 4'h7);
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        #1 chk("T6_rst_rdy", {7'd0, in_ready}, 8'd1);
        chk("T6_rst_vld", {7'd0, out_valid}, 8'd0);
        @(negedge clk) rst_n = 1'b1;
        repeat (12) @(posedge clk);
        #1 chk("T6_no_vld", {7'd0, out_valid}, 8'd0);
        chk("T6_post_rdy", {7'd0, in_ready}, 8'd1);

        run_vec("T6_rerun", 4'h3, 4'h9, 4'h7, 4'h3, 4'h2, 4'h0, 2'd2, 1'b0);
        release_out("T6_rerun");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
